// File: rtl/ifm_feeder.sv
// Feeds one rate-coded ifm bitstream to a PE row edge per MAC pass.
// The ifm magnitude is compared against a bit-reversed counter to give a low-discrepancy bitstream.
module ifm_feeder #(
    parameter int unsigned IWIDTH = 8,
    parameter int unsigned CWIDTH = IWIDTH + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CWIDTH-1:0] i_cycle_len,
    input  logic [IWIDTH-1:0] i_ifm,
    input  logic              i_ifm_vld,
    output logic              o_ifm_rdy,
    output logic              o_ifm_dff,
    output logic              o_en_i,
    output logic              o_clr_i,
    output logic              o_en_w,
    output logic              o_clr_w,
    output logic              o_en_o,
    output logic              o_clr_o,
    output logic              o_mac_done,
    output logic              o_busy
);

    localparam int unsigned LW = (CWIDTH > IWIDTH + 1) ? CWIDTH : IWIDTH + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(1) << IWIDTH;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLEAR    = 3'd1,
        WLOAD    = 3'd2,
        WAIT_IFM = 3'd3,
        RUN      = 3'd4,
        DONE     = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CWIDTH-1:0]   r_cnt;
    logic [CWIDTH-1:0]   r_len_q;
    logic [IWIDTH-1:0]   r_ifm_q;
    logic [CWIDTH-1:0]   w_len_clamp;
    logic [IWIDTH-1:0]   w_cnt_lo;
    logic [IWIDTH-1:0]   w_rev;
    logic                w_last;

    // Lengths beyond one full sequence would only repeat values, so they saturate.
    assign w_len_clamp = (LW'(i_cycle_len) > MAX_LEN) ? CWIDTH'(MAX_LEN) : i_cycle_len;
    assign w_last      = (r_cnt == r_len_q - CWIDTH'(1));

    always_comb begin
        w_cnt_lo = IWIDTH'(r_cnt);
        w_rev    = '0;
        for (int i = 0; i < int'(IWIDTH); i++) begin
            w_rev[i] = w_cnt_lo[IWIDTH-1-i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and Moore output decode.
    always_comb begin
        w_state_nxt = r_state;
        o_ifm_rdy   = 1'b0;
        o_ifm_dff   = 1'b0;
        o_en_i      = 1'b0;
        o_clr_i     = 1'b0;
        o_en_w      = 1'b0;
        o_clr_w     = 1'b0;
        o_en_o      = 1'b0;
        o_clr_o     = 1'b0;
        o_mac_done  = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                o_clr_i     = 1'b1;
                o_clr_w     = 1'b1;
                o_clr_o     = 1'b1;
                w_state_nxt = WLOAD;
            end
            WLOAD: begin
                o_en_w      = 1'b1;
                w_state_nxt = WAIT_IFM;
            end
            WAIT_IFM: begin
                o_ifm_rdy = 1'b1;
                if (i_ifm_vld) begin
                    w_state_nxt = (r_len_q != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                o_en_i    = 1'b1;
                o_en_o    = 1'b1;
                o_ifm_dff = (r_ifm_q > w_rev);
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                o_mac_done  = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_len_q <= '0;
            r_ifm_q <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_len_q <= w_len_clamp;
                    end
                end
                WAIT_IFM: begin
                    if (i_ifm_vld) begin
                        r_ifm_q <= i_ifm;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_cnt <= r_cnt + CWIDTH'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
